// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: control encodings shared by the decoder and fetch stage
package cpu_ctrl_pkg;
  localparam logic [1:0] BT_BEQ  = 2'd0;
  localparam logic [1:0] BT_BLE  = 2'd1;
  localparam logic [1:0] BT_BLT  = 2'd2;
  localparam logic [1:0] BT_BNEZ = 2'd3;
  localparam logic [1:0] JMP_NO  = 2'd0;
  localparam logic [1:0] JMP_J   = 2'd1;
  localparam logic [1:0] JMP_JR  = 2'd2;
  localparam logic [31:0] NOP_INSTR = 32'h0;
endpackage

// File: rtl/instr_fetch_unit_branch_resolve.sv
// branch_resolve: decides whether the IF/ID instruction redirects fetch and where to
module branch_resolve
  import cpu_ctrl_pkg::*;
(
  input  logic        valid_i,
  input  logic        branch_i,
  input  logic [1:0]  branch_type_i,
  input  logic [1:0]  jump_i,
  input  logic        zero_i,
  input  logic        neg_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic        taken_o,
  output logic [31:0] target_o
);
  logic w_cond;
  logic w_jmp;
  logic w_unused;
  assign w_unused = ^{instr_i[31:26], imm_i[31:30], rs_data_i[1:0]};
  always_comb begin
    w_cond   = branch_type_i == BT_BEQ ? zero_i :
               branch_type_i == BT_BLE ? (zero_i | neg_i) :
               branch_type_i == BT_BLT ? neg_i : !zero_i;
    w_jmp    = jump_i == JMP_J || jump_i == JMP_JR;
    taken_o  = valid_i & (w_jmp | (branch_i & w_cond));
    target_o = jump_i == JMP_J  ? {pc4_i[31:28], instr_i[25:0], 2'b00} :
               jump_i == JMP_JR ? {rs_data_i[31:2], 2'b00} :
               pc4_i + {imm_i[29:0], 2'b00};
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register, IF/ID pipeline register and redirect/flush handling
module instr_fetch_unit
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      instr_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic [1:0]       branch_type_i,
  input  logic [1:0]       jump_i,
  input  logic             zero_i,
  input  logic             neg_i,
  input  logic [31:0]      imm_i,
  input  logic [31:0]      rs_data_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      if_id_instr_o,
  output logic [31:0]      if_id_pc4_o,
  output logic             if_id_valid_o,
  output logic             redirect_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [31:0]      r_pc4;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      w_pc4;
  logic [31:0]      w_target;
  logic             w_redirect;
  assign w_pc4 = r_pc + 32'd4;
  branch_resolve u_resolve (
    .valid_i       (r_valid),
    .branch_i      (branch_i),
    .branch_type_i (branch_type_i),
    .jump_i        (jump_i),
    .zero_i        (zero_i),
    .neg_i         (neg_i),
    .imm_i         (imm_i),
    .rs_data_i     (rs_data_i),
    .instr_i       (r_instr),
    .pc4_i         (r_pc4),
    .taken_o       (w_redirect),
    .target_o      (w_target)
  );
  // A redirect wins over stall: the wrong-path fetch is squashed into a bubble
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (w_redirect) begin
      r_pc    <= w_target;
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= &r_cnt ? r_cnt : r_cnt + CNT_W'(1);
    end else if (!stall_i) begin
      r_pc    <= w_pc4;
      r_instr <= instr_i;
      r_pc4   <= w_pc4;
      r_valid <= 1'b1;
    end
  end
  assign pc_o          = r_pc;
  assign if_id_instr_o = r_instr;
  assign if_id_pc4_o   = r_pc4;
  assign if_id_valid_o = r_valid;
  assign redirect_o    = w_redirect;
  assign flush_cnt_o   = r_cnt;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench for the fetch stage
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic        stall_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [1:0]  branch_type_i = '0;
  logic [1:0]  jump_i = '0;
  logic        zero_i = 1'b0;
  logic        neg_i = 1'b0;
  logic [31:0] imm_i = '0;
  logic [31:0] rs_data_i = '0;
  logic [31:0] pc_o, if_id_instr_o, if_id_pc4_o;
  logic        if_id_valid_o, redirect_o;
  logic [15:0] flush_cnt_o;
  logic [31:0] s_pc, s_instr, s_pc4;
  logic        s_valid, s_redirect;
  logic [3:0]  s_cnt;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_fetch_unit u_dut (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .stall_i(stall_i),
    .branch_i(branch_i), .branch_type_i(branch_type_i), .jump_i(jump_i),
    .zero_i(zero_i), .neg_i(neg_i), .imm_i(imm_i), .rs_data_i(rs_data_i),
    .pc_o(pc_o), .if_id_instr_o(if_id_instr_o), .if_id_pc4_o(if_id_pc4_o),
    .if_id_valid_o(if_id_valid_o), .redirect_o(redirect_o), .flush_cnt_o(flush_cnt_o)
  );

  // Narrow-counter copy so saturation is reachable in a short run
  instr_fetch_unit #(.CNT_W(4)) u_sat (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .stall_i(stall_i),
    .branch_i(branch_i), .branch_type_i(branch_type_i), .jump_i(jump_i),
    .zero_i(zero_i), .neg_i(neg_i), .imm_i(imm_i), .rs_data_i(rs_data_i),
    .pc_o(s_pc), .if_id_instr_o(s_instr), .if_id_pc4_o(s_pc4),
    .if_id_valid_o(s_valid), .redirect_o(s_redirect), .flush_cnt_o(s_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    stall_i = 0; branch_i = 0; branch_type_i = 0; jump_i = 0;
    zero_i = 0; neg_i = 0; imm_i = 0; rs_data_i = 0;
  endtask

  task automatic test_reset();
    #1 rst_i = 1;
    #1;
    n_checks++;
    if ({pc_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, redirect_o, flush_cnt_o} !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset: pc=%h instr=%h pc4=%h v=%b rd=%b cnt=%h, want all zero", pc_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, redirect_o, flush_cnt_o);
    end
    @(posedge clk);
    #1 rst_i = 0;
    n_checks++;
    if (pc_o !== 32'h0) begin
      n_fail++;
      $display("FAIL run_c0: pc=%h want 0", pc_o);
    end
    for (int i = 1; i <= 3; i++) begin
      instr_i = 32'hA000_0000 + 32'(4 * (i - 1));
      tick();
      n_checks++;
      if ({pc_o, if_id_valid_o, if_id_pc4_o, if_id_instr_o} !== {32'(4 * i), 1'b1, 32'(4 * i), 32'hA000_0000 + 32'(4 * (i - 1))}) begin
        n_fail++;
        $display("FAIL run_c%0d: pc=%h v=%b pc4=%h instr=%h want pc=pc4=%h", i, pc_o, if_id_valid_o, if_id_pc4_o, if_id_instr_o, 4 * i);
      end
    end
  endtask

  task automatic test_branch();
    instr_i = 32'hA000_000C;
    tick();
    branch_i = 1; branch_type_i = 2'd0; imm_i = 32'd3; zero_i = 1;
    #1;
    n_checks++;
    if (redirect_o !== 1'b1) begin
      n_fail++;
      $display("FAIL beq_taken_rd: got %b want 1", redirect_o);
    end
    tick();
    n_checks++;
    if ({pc_o, if_id_valid_o, if_id_instr_o, if_id_pc4_o, flush_cnt_o} !== {32'h1C, 1'b0, 32'h0, 32'h0, 16'd1}) begin
      n_fail++;
      $display("FAIL beq_taken: pc=%h v=%b instr=%h pc4=%h cnt=%h want pc=1c bubble cnt=1", pc_o, if_id_valid_o, if_id_instr_o, if_id_pc4_o, flush_cnt_o);
    end
    clear_ctrl();
    tick();
    branch_i = 1; branch_type_i = 2'd0; imm_i = 32'd3; zero_i = 0;
    #1;
    n_checks++;
    if (redirect_o !== 1'b0) begin
      n_fail++;
      $display("FAIL beq_not_rd: got %b want 0", redirect_o);
    end
    branch_type_i = 2'd1; neg_i = 1;
    #1;
    n_checks++;
    if (redirect_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ble_neg_rd: got %b want 1", redirect_o);
    end
    branch_type_i = 2'd2; neg_i = 0; zero_i = 1;
    #1;
    n_checks++;
    if (redirect_o !== 1'b0) begin
      n_fail++;
      $display("FAIL blt_zero_rd: got %b want 0", redirect_o);
    end
    branch_type_i = 2'd0; zero_i = 0;
    tick();
    n_checks++;
    if ({pc_o, if_id_valid_o, if_id_pc4_o, flush_cnt_o} !== {32'h24, 1'b1, 32'h24, 16'd1}) begin
      n_fail++;
      $display("FAIL beq_not: pc=%h v=%b pc4=%h cnt=%h want pc=24 v=1 pc4=24 cnt=1", pc_o, if_id_valid_o, if_id_pc4_o, flush_cnt_o);
    end
    branch_type_i = 2'd3; zero_i = 0; imm_i = 32'hFFFF_FFFC;
    tick();
    n_checks++;
    if ({pc_o, if_id_valid_o, flush_cnt_o} !== {32'h14, 1'b0, 16'd2}) begin
      n_fail++;
      $display("FAIL bnez_back: pc=%h v=%b cnt=%h want pc=14 v=0 cnt=2", pc_o, if_id_valid_o, flush_cnt_o);
    end
    clear_ctrl();
    jump_i = 2'd1;
    #1;
    n_checks++;
    if (redirect_o !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_gate: rd=%b want 0", redirect_o);
    end
    tick();
    clear_ctrl();
    n_checks++;
    if ({pc_o, if_id_valid_o, if_id_pc4_o, flush_cnt_o} !== {32'h18, 1'b1, 32'h18, 16'd2}) begin
      n_fail++;
      $display("FAIL invalid_gate_adv: pc=%h v=%b pc4=%h cnt=%h want pc=18 v=1 pc4=18 cnt=2", pc_o, if_id_valid_o, if_id_pc4_o, flush_cnt_o);
    end
  endtask

  task automatic test_jr_stall();
    jump_i = 2'd2; rs_data_i = 32'h0000_0103; stall_i = 1;
    #1;
    n_checks++;
    if (redirect_o !== 1'b1) begin
      n_fail++;
      $display("FAIL jr_rd: got %b want 1", redirect_o);
    end
    tick();
    clear_ctrl();
    n_checks++;
    if ({pc_o, if_id_valid_o, flush_cnt_o} !== {32'h100, 1'b0, 16'd3}) begin
      n_fail++;
      $display("FAIL jr_stall: pc=%h v=%b cnt=%h want pc=100 v=0 cnt=3", pc_o, if_id_valid_o, flush_cnt_o);
    end
  endtask

  task automatic test_jump();
    instr_i = 32'h0;
    tick();
    jump_i = 2'd2; rs_data_i = 32'h4000_0004;
    tick();
    clear_ctrl();
    instr_i = 32'h0800_0040;
    tick();
    n_checks++;
    if ({pc_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o} !== {32'h4000_0008, 32'h0800_0040, 32'h4000_0008, 1'b1}) begin
      n_fail++;
      $display("FAIL j_setup: pc=%h instr=%h pc4=%h v=%b", pc_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o);
    end
    jump_i = 2'd1;
    tick();
    clear_ctrl();
    n_checks++;
    if ({pc_o, if_id_valid_o, flush_cnt_o} !== {32'h4000_0100, 1'b0, 16'd5}) begin
      n_fail++;
      $display("FAIL j_target: pc=%h v=%b cnt=%h want pc=40000100 v=0 cnt=5", pc_o, if_id_valid_o, flush_cnt_o);
    end
    instr_i = 32'hDEAD_BEEF;
    tick();
    jump_i = 2'd3;
    #1;
    n_checks++;
    if (redirect_o !== 1'b0) begin
      n_fail++;
      $display("FAIL jmp_reserved: rd=%b want 0", redirect_o);
    end
    clear_ctrl();
  endtask

  task automatic test_stall();
    instr_i = 32'h1234_5678;
    tick();
    stall_i = 1;
    instr_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({pc_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o} !== {32'h4000_0108, 32'h1234_5678, 32'h4000_0108, 1'b1}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: pc=%h instr=%h pc4=%h v=%b want pc=pc4=40000108 instr=12345678", i, pc_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o);
      end
    end
    stall_i = 0;
    tick();
    n_checks++;
    if ({pc_o, if_id_instr_o, if_id_pc4_o, flush_cnt_o} !== {32'h4000_010C, 32'hFFFF_FFFF, 32'h4000_010C, 16'd5}) begin
      n_fail++;
      $display("FAIL stall_resume: pc=%h instr=%h pc4=%h cnt=%h", pc_o, if_id_instr_o, if_id_pc4_o, flush_cnt_o);
    end
  endtask

  task automatic test_wrap();
    jump_i = 2'd2; rs_data_i = 32'hFFFF_FFFF;
    tick();
    clear_ctrl();
    n_checks++;
    if ({pc_o, flush_cnt_o} !== {32'hFFFF_FFFC, 16'd6}) begin
      n_fail++;
      $display("FAIL wrap_setup: pc=%h cnt=%h want fffffffc 6", pc_o, flush_cnt_o);
    end
    instr_i = 32'hAAAA_5555;
    tick();
    n_checks++;
    if ({pc_o, if_id_pc4_o, if_id_valid_o, if_id_instr_o} !== {32'h0, 32'h0, 1'b1, 32'hAAAA_5555}) begin
      n_fail++;
      $display("FAIL wrap: pc=%h pc4=%h v=%b instr=%h want pc=0 pc4=0 v=1", pc_o, if_id_pc4_o, if_id_valid_o, if_id_instr_o);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 12; i++) begin
      jump_i = 2'd2; rs_data_i = 32'h200;
      tick();
      n_checks++;
      if ({flush_cnt_o, s_cnt} !== {16'(7 + i), (7 + i > 15) ? 4'hF : 4'(7 + i)}) begin
        n_fail++;
        $display("FAIL saturate%0d: cnt=%h sat_cnt=%h want %h %h", i, flush_cnt_o, s_cnt, 7 + i, (7 + i > 15) ? 15 : 7 + i);
      end
      clear_ctrl();
      tick();
    end
  endtask

  task automatic test_async_reset();
    jump_i = 2'd1;
    #2 rst_i = 1;
    #1;
    n_checks++;
    if ({pc_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, redirect_o, flush_cnt_o, s_cnt} !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h instr=%h pc4=%h v=%b rd=%b cnt=%h sat=%h want zeros", pc_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, redirect_o, flush_cnt_o, s_cnt);
    end
    clear_ctrl();
    @(posedge clk);
    #1 rst_i = 0;
    tick();
    n_checks++;
    if ({pc_o, if_id_valid_o, if_id_pc4_o, flush_cnt_o} !== {32'h4, 1'b1, 32'h4, 16'h0}) begin
      n_fail++;
      $display("FAIL post_reset: pc=%h v=%b pc4=%h cnt=%h want pc=4 v=1 pc4=4 cnt=0", pc_o, if_id_valid_o, if_id_pc4_o, flush_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jr_stall();
    test_jump();
    test_stall();
    test_wrap();
    test_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
